// File: rtl/bpf_alu_pkg.sv
// bpf_alu_pkg: BPF ALU opcode constants, FSM state encoding and opcode helper shared with the decoder
package bpf_alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_AND = 4'd5;
  localparam logic [3:0] OP_LSH = 4'd6;
  localparam logic [3:0] OP_RSH = 4'd7;
  localparam logic [3:0] OP_NEG = 4'd8;
  localparam logic [3:0] OP_MOD = 4'd9;
  localparam logic [3:0] OP_XOR = 4'd10;
  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIN} state_e;
  function automatic logic is_div_op(input logic [3:0] op);
    return op == OP_DIV || op == OP_MOD;
  endfunction
endpackage

// File: rtl/bpf_alu_if.sv
// bpf_alu_if: controller<->ALU bundle (start/op/a/b in; busy/done/result/div_zero out); master=controller, slave=ALU
interface bpf_alu_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_zero;
  modport master (output start, op, a, b, input busy, done, result, div_zero);
  modport slave (input start, op, a, b, output busy, done, result, div_zero);
endinterface

// File: rtl/bpf_alu_serial_divider.sv
// bpf_alu_serial_divider: 32-step unsigned restoring divider; start_i/dividend_i/divisor_i in, busy_o/done_o (last step) and post-step quotient_o/remainder_o out
module bpf_alu_serial_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q;
  logic [32:0] trial, diff;
  logic [5:0]  cnt_q;
  logic        busy_q;
  always_comb begin
    trial = {rem_q, quo_q[31]};
    diff  = trial - {1'b0, dvs_q};
    rem_d = diff[32] ? trial[31:0] : diff[31:0];
    quo_d = {quo_q[30:0], ~diff[32]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i && !busy_q) begin
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
      rem_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      cnt_q  <= done_o ? 6'd0 : cnt_q + 6'd1;
      busy_q <= !done_o;
    end
  end
  assign busy_o      = busy_q;
  assign done_o      = busy_q && cnt_q == 6'd31;
  assign quotient_o  = quo_d;
  assign remainder_o = rem_d;
endmodule

// File: rtl/bpf_alu.sv
// bpf_alu: BPF ALU-class accumulator update; clk/rst plus slave bus (single-cycle ops, 33-cycle DIV/MOD, registered result/done/div_zero)
module bpf_alu
  import bpf_alu_pkg::*;
(
  input logic       clk,
  input logic       rst,
  bpf_alu_if.slave  alu
);
  state_e      state_q, state_d;
  logic [31:0] result_q, result_d, alu_res, quo, rem;
  logic        done_q, done_d, dz_q, dz_d, mod_q, mod_d;
  logic        div_start, div_busy, div_done, shift_oor;
  assign shift_oor = |alu.b[31:5];
  always_comb begin
    alu_res = alu.op == OP_ADD ? alu.a + alu.b :
              alu.op == OP_SUB ? alu.a - alu.b :
              alu.op == OP_MUL ? alu.a * alu.b :
              alu.op == OP_OR  ? alu.a | alu.b :
              alu.op == OP_AND ? alu.a & alu.b :
              alu.op == OP_LSH ? (shift_oor ? 32'd0 : alu.a << alu.b[4:0]) :
              alu.op == OP_RSH ? (shift_oor ? 32'd0 : alu.a >> alu.b[4:0]) :
              alu.op == OP_NEG ? -alu.a :
              alu.op == OP_XOR ? alu.a ^ alu.b : 32'd0;
  end
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    done_d    = 1'b0;
    dz_d      = dz_q;
    mod_d     = mod_q;
    div_start = 1'b0;
    if (state_q == S_DIV) begin
      if (div_done) begin
        state_d  = S_FIN;
        result_d = mod_q ? rem : quo;
        dz_d     = 1'b0;
        done_d   = 1'b1;
      end
    end else if (alu.start && is_div_op(alu.op) && |alu.b) begin
      state_d   = S_DIV;
      div_start = 1'b1;
      mod_d     = alu.op == OP_MOD;
    end else if (alu.start) begin
      state_d  = S_IDLE;
      result_d = alu_res;
      dz_d     = is_div_op(alu.op);
      done_d   = 1'b1;
    end else begin
      state_d = S_IDLE;
    end
  end
  bpf_alu_serial_divider u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .dividend_i  (alu.a),
    .divisor_i   (alu.b),
    .busy_o      (div_busy),
    .done_o      (div_done),
    .quotient_o  (quo),
    .remainder_o (rem)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      mod_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      mod_q    <= mod_d;
    end
  end
  assign alu.busy     = div_busy;
  assign alu.done     = done_q;
  assign alu.result   = result_q;
  assign alu.div_zero = dz_q;
endmodule
